// File: rtl/fx_pipe_arbiter.sv
// fx_pipe_arbiter: round-robin front end that shares one fixed-latency
// FP pipeline between four channels and routes each result back.
//
// Ports:
//   clk           rising-edge clock
//   aclr          asynchronous, active-high reset
//   chan_en       per-channel enable mask (disabled channels never granted)
//   req_valid     per-channel sample request
//   req_data      channel i sample in bits [i*DATA_W +: DATA_W]
//   req_ready     one-hot grant, combinational
//   pipe_in_data  registered operand to the shared FP pipeline
//   pipe_out_data FP pipeline result
//   resp_valid    one-hot result strobe, LATENCY cycles after issue
//   resp_data     registered result sample
//   inflight      number of issued samples not yet returned
//
// Parameters:
//   LATENCY       issue-to-result cycle count (2..63)
//   DATA_W        sample width
module fx_pipe_arbiter #(
    parameter int LATENCY = 48,
    parameter int DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic [3:0]            chan_en,
    input  logic [3:0]            req_valid,
    input  logic [4*DATA_W-1:0]   req_data,
    output logic [3:0]            req_ready,
    output logic [DATA_W-1:0]     pipe_in_data,
    input  logic [DATA_W-1:0]     pipe_out_data,
    output logic [3:0]            resp_valid,
    output logic [DATA_W-1:0]     resp_data,
    output logic [6:0]            inflight
);

    // ------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------
    logic [1:0]        ptr;
    logic [3:0]        elig;
    logic [3:0]        grant;
    logic [1:0]        gidx;
    logic              found;
    logic [1:0]        idx;
    logic              xfer;
    logic [DATA_W-1:0] sel_data;

    // Search starts one past the last winner, wrapping mod 4.
    always_comb begin
        elig  = req_valid & chan_en;
        grant = 4'b0000;
        gidx  = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && elig[idx]) begin
                found       = 1'b1;
                gidx        = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

    // Grant is forced low while reset is held.
    assign req_ready = aclr ? 4'b0000 : grant;

    // The grant only ever covers a valid channel, so any grant is a transfer.
    assign xfer = |req_ready;

    assign sel_data = req_data[gidx*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            ptr <= 2'd3;
        end else if (xfer) begin
            ptr <= gidx;
        end
    end

    // ------------------------------------------------------------
    // Issue register
    // ------------------------------------------------------------
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            pipe_in_data <= '0;
        end else if (xfer) begin
            pipe_in_data <= sel_data;
        end
    end

    // ------------------------------------------------------------
    // Tag tracking
    // ------------------------------------------------------------
    // Slot 0 is loaded on the issue edge; the entry reaches the top
    // slot LATENCY-1 edges later and is consumed on the next edge,
    // the same edge that captures the matching pipeline result.
    logic [LATENCY-1:0] sr_vld;
    logic [1:0]         sr_tag [LATENCY];
    logic               ret;
    logic [1:0]         ret_tag;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            sr_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                sr_tag[i] <= 2'd0;
            end
        end else begin
            sr_vld    <= {sr_vld[LATENCY-2:0], xfer};
            sr_tag[0] <= gidx;
            for (int i = 1; i < LATENCY; i++) begin
                sr_tag[i] <= sr_tag[i-1];
            end
        end
    end

    assign ret     = sr_vld[LATENCY-1];
    assign ret_tag = sr_tag[LATENCY-1];

    // ------------------------------------------------------------
    // Response
    // ------------------------------------------------------------
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            resp_valid <= 4'b0000;
            resp_data  <= '0;
        end else begin
            resp_valid <= ret ? (4'b0001 << ret_tag) : 4'b0000;
            if (ret) begin
                resp_data <= pipe_out_data;
            end
        end
    end

    // ------------------------------------------------------------
    // In-flight count
    // ------------------------------------------------------------
    // Mirrors the number of set bits in sr_vld, so it is bounded by LATENCY.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            inflight <= 7'd0;
        end else begin
            unique case ({xfer, ret})
                2'b10:   inflight <= inflight + 7'd1;
                2'b01:   inflight <= inflight - 7'd1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule
